mem_op_seq: RTL and testbench

Operation sequencer sitting directly upstream of `mem_array`. It accepts one-cell read or write requests over a valid/ready handshake, then drives the array's addressing, voltage and strobe inputs in a fixed per-phase order: `addr_tar`, `read_mode`, `V_BL`, `V_WL`, the SL voltage bus, and `bl/wl/sl_assert_en` followed by `tran_en`. It captures the selected SL current on reads and returns a response over a second valid/ready handshake.

---
 rtl/mem_op_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_mem_op_seq.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_op_seq.sv
// mem_op_seq: one-cell read/write sequencer driving mem_array strobes.
// Optional write-verify loop: define MEM_OP_SEQ_VERIFY_EN.
module mem_op_seq #(
  parameter int  PULSE_CYC = 4,
  parameter int  MAX_RETRY = 7,
  parameter real VSTEP     = 0.05,
  parameter real VREAD     = 0.2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [9:0] req_addr,
  input  logic       req_read,
  input  real        req_vbl,
  input  real        req_vwl,
  input  real        req_vsl,
  input  real        req_ilo,
  input  real        req_ihi,
  output logic       resp_valid,
  input  logic       resp_ready,
  output real        resp_i,
  output logic       resp_err,
  output logic [3:0] resp_tries,
  output logic [9:0] addr_tar,
  output logic       read_mode,
  output real        V_BL [32],
  output real        V_WL [32],
  output real        V_SL [32],
  output logic       bl_assert_en,
  output logic       wl_assert_en,
  output logic       sl_assert_en,
  output logic       tran_en,
  input  real        sl_i [32]
);

  localparam int PW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ASSERT,
    S_PULSE,
    S_CAPTURE,
    S_RESP
`ifdef MEM_OP_SEQ_VERIFY_EN
    ,
    S_VSETUP,
    S_VCHECK
`endif
  } state_e;

  state_e state_q, state_d;
  logic          init_q;
  logic [9:0]    addr_q, addr_d;
  logic          rd_q, rd_d;
  logic          mode_q, mode_d;
  real           vbl_q, vbl_d;
  real           vwl_q, vwl_d;
  real           vsl_q, vsl_d;
  logic [3:0]    tries_q, tries_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  real           ri_q, ri_d;
  logic          err_q, err_d;
`ifdef MEM_OP_SEQ_VERIFY_EN
  real           ilo_q, ilo_d;
  real           ihi_q, ihi_d;
`else
  logic          unused_cfg;
  assign unused_cfg = (req_ilo > req_ihi) ^ (VSTEP > 0.0)
                    ^ (MAX_RETRY > 0);
`endif

  logic        drive;
  logic        vrfy_rd;
  logic [4:0]  row;
  logic [4:0]  col;

  assign row        = addr_q[9:5];
  assign col        = addr_q[4:0];
  assign req_ready  = init_q && (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_i     = ri_q;
  assign resp_err   = err_q;
  assign resp_tries = tries_q;
  assign addr_tar   = addr_q;
  assign read_mode  = mode_q;
  // a read phase belonging to a write request is the verify read
  assign vrfy_rd    = mode_q && !rd_q;

  // state and request registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      init_q  <= 1'b0;
      addr_q  <= '0;
      rd_q    <= 1'b1;
      mode_q  <= 1'b1;
      vbl_q   <= 0.0;
      vwl_q   <= 0.0;
      vsl_q   <= 0.0;
      tries_q <= '0;
      pcnt_q  <= '0;
      ri_q    <= 0.0;
      err_q   <= 1'b0;
`ifdef MEM_OP_SEQ_VERIFY_EN
      ilo_q   <= 0.0;
      ihi_q   <= 0.0;
`endif
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      mode_q  <= mode_d;
      vbl_q   <= vbl_d;
      vwl_q   <= vwl_d;
      vsl_q   <= vsl_d;
      tries_q <= tries_d;
      pcnt_q  <= pcnt_d;
      ri_q    <= ri_d;
      err_q   <= err_d;
`ifdef MEM_OP_SEQ_VERIFY_EN
      ilo_q   <= ilo_d;
      ihi_q   <= ihi_d;
`endif
    end
  end

  // next-state and register update logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    mode_d  = mode_q;
    vbl_d   = vbl_q;
    vwl_d   = vwl_q;
    vsl_d   = vsl_q;
    tries_d = tries_q;
    pcnt_d  = pcnt_q;
    ri_d    = ri_q;
    err_d   = err_q;
`ifdef MEM_OP_SEQ_VERIFY_EN
    ilo_d   = ilo_q;
    ihi_d   = ihi_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = S_SETUP;
          addr_d  = req_addr;
          rd_d    = req_read;
          mode_d  = req_read;
          vbl_d   = req_vbl;
          vwl_d   = req_vwl;
          vsl_d   = req_vsl;
          tries_d = '0;
          ri_d    = 0.0;
          err_d   = 1'b0;
`ifdef MEM_OP_SEQ_VERIFY_EN
          ilo_d   = req_ilo;
          ihi_d   = req_ihi;
`endif
        end
      end
      S_SETUP: state_d = S_ASSERT;
      S_ASSERT: begin
        state_d = S_PULSE;
        pcnt_d  = '0;
        if (!mode_q) tries_d = tries_q + 4'd1;
      end
      S_PULSE: begin
        if (pcnt_q == PW'(PULSE_CYC - 1)) state_d = S_CAPTURE;
        else pcnt_d = pcnt_q + PW'(1);
      end
      S_CAPTURE: begin
        state_d = S_RESP;
        if (mode_q) ri_d = sl_i[col];
`ifdef MEM_OP_SEQ_VERIFY_EN
        if (!rd_q) begin
          if (!mode_q) begin
            state_d = S_VSETUP;
            mode_d  = 1'b1;
          end else begin
            state_d = S_VCHECK;
          end
        end
`endif
      end
`ifdef MEM_OP_SEQ_VERIFY_EN
      S_VSETUP: state_d = S_ASSERT;
      S_VCHECK: begin
        if (ri_q >= ilo_q && ri_q <= ihi_q) begin
          state_d = S_RESP;
          err_d   = 1'b0;
        end else if (int'(tries_q) < MAX_RETRY + 1) begin
          state_d = S_SETUP;
          mode_d  = 1'b0;
          vwl_d   = vwl_q + VSTEP;
        end else begin
          state_d = S_RESP;
          err_d   = 1'b1;
        end
      end
`endif
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // array voltages and strobes decoded from the current phase
  always_comb begin
    for (int i = 0; i < 32; i++) begin
      V_BL[i] = 0.0;
      V_WL[i] = 0.0;
      V_SL[i] = 0.0;
    end
    bl_assert_en = 1'b0;
    wl_assert_en = 1'b0;
    sl_assert_en = 1'b0;
    tran_en      = 1'b0;
    drive = (state_q == S_SETUP) || (state_q == S_ASSERT)
         || (state_q == S_PULSE) || (state_q == S_CAPTURE);
`ifdef MEM_OP_SEQ_VERIFY_EN
    if (state_q == S_VSETUP) drive = 1'b1;
`endif
    if (drive) begin
      V_BL[row] = vrfy_rd ? VREAD : vbl_q;
      if (!mode_q) begin
        V_WL[col] = vwl_q;
        V_SL[col] = vsl_q;
      end
    end
    if (state_q == S_ASSERT) begin
      bl_assert_en = 1'b1;
      wl_assert_en = 1'b1;
      sl_assert_en = 1'b1;
    end
    if (state_q == S_PULSE) tran_en = 1'b1;
  end

endmodule

// File: tb/tb_mem_op_seq.sv
// tb_mem_op_seq: vector table + scoreboard bench for mem_op_seq.
// Array modelled as a fresh cell: sl_i[col] = 350 * V_BL[row].
module tb_mem_op_seq;

  localparam int PC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [9:0] req_addr = '0;
  logic       req_read = 1'b0;
  real        req_vbl = 0.0;
  real        req_vwl = 0.0;
  real        req_vsl = 0.0;
  real        req_ilo = 0.0;
  real        req_ihi = 0.0;
  logic       resp_valid;
  logic       resp_ready = 1'b0;
  real        resp_i;
  logic       resp_err;
  logic [3:0] resp_tries;
  logic [9:0] addr_tar;
  logic       read_mode;
  real        V_BL [32];
  real        V_WL [32];
  real        V_SL [32];
  logic       bl_assert_en;
  logic       wl_assert_en;
  logic       sl_assert_en;
  logic       tran_en;
  real        sl_i [32];

  mem_op_seq dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_read(req_read),
    .req_vbl(req_vbl), .req_vwl(req_vwl), .req_vsl(req_vsl),
    .req_ilo(req_ilo), .req_ihi(req_ihi),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_i(resp_i), .resp_err(resp_err), .resp_tries(resp_tries),
    .addr_tar(addr_tar), .read_mode(read_mode),
    .V_BL(V_BL), .V_WL(V_WL), .V_SL(V_SL),
    .bl_assert_en(bl_assert_en), .wl_assert_en(wl_assert_en),
    .sl_assert_en(sl_assert_en), .tran_en(tran_en),
    .sl_i(sl_i)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int c = 0; c < 32; c++) sl_i[c] = 0.0;
    sl_i[addr_tar[4:0]] = 350.0 * V_BL[addr_tar[9:5]];
  end

  typedef struct {
    logic [9:0] addr;
    logic       rd;
    real        vbl;
    real        vwl;
    real        vsl;
    real        ilo;
    real        ihi;
    real        ei;
    int         et;
    logic       ee;
    int         lat;
  } vec_t;

  typedef struct {
    real  i;
    int   tries;
    logic err;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[6];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input real act, input real exp);
    n_chk++;
    if (act > exp + 1e-6 || act < exp - 1e-6) begin
      n_fail++;
      $display("FAIL %s: got %0.4f expected %0.4f", nm, act, exp);
    end
  endtask

  function automatic real vsum();
    real s;
    s = 0.0;
    for (int i = 0; i < 32; i++) begin
      s += (V_BL[i] < 0.0) ? -V_BL[i] : V_BL[i];
      s += (V_WL[i] < 0.0) ? -V_WL[i] : V_WL[i];
      s += (V_SL[i] < 0.0) ? -V_SL[i] : V_SL[i];
    end
    return s;
  endfunction

  function automatic vec_t mk(input logic [9:0] a, input logic rd,
                              input real vb, input real vw,
                              input real vs);
    vec_t v;
    v.addr = a; v.rd = rd; v.vbl = vb; v.vwl = vw; v.vsl = vs;
    v.ilo = 60.0; v.ihi = 80.0; v.ee = 1'b0;
    if (rd) begin
      v.ei = 350.0 * vb; v.et = 0; v.lat = PC + 4;
    end else begin
`ifdef MEM_OP_SEQ_VERIFY_EN
      v.ei = 70.0; v.et = 1; v.lat = 2 * PC + 8;
`else
      v.ei = 0.0; v.et = 1; v.lat = PC + 4;
`endif
    end
    return v;
  endfunction

  task automatic drive_req(input vec_t v);
    exp_t e;
    req_valid = 1'b1;
    req_addr = v.addr; req_read = v.rd;
    req_vbl = v.vbl; req_vwl = v.vwl; req_vsl = v.vsl;
    req_ilo = v.ilo; req_ihi = v.ihi;
    e.i = v.ei; e.tries = v.et; e.err = v.ee;
    sb.push_back(e);
  endtask

  task automatic check_resp(input string nm);
    exp_t e;
    if (sb.size() == 0) begin
      chk({nm, "_sb_underflow"}, 1.0, 0.0);
    end else begin
      e = sb.pop_front();
      chk({nm, "_resp_i"}, resp_i, e.i);
      chk({nm, "_resp_tries"}, resp_tries, e.tries);
      chk({nm, "_resp_err"}, resp_err, e.err);
    end
  endtask

  // full operation with per-cycle phase checks; resp_ready held high
  task automatic run_op(input vec_t v);
    int cyc;
    real ewl, esl, es;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1.0);
    resp_ready = 1'b1;
    drive_req(v);
    @(negedge clk);
    req_valid = 1'b0;
    ewl = v.rd ? 0.0 : v.vwl;
    esl = v.rd ? 0.0 : v.vsl;
    es  = v.vbl + ewl + esl;
    for (int k = 1; k <= PC + 3; k++) begin
      if (k > 1) @(negedge clk);
      chk("req_ready_busy", req_ready, 0.0);
      chk("tran_en", tran_en, (k >= 3 && k <= PC + 2) ? 1.0 : 0.0);
      chk("assert_en", {bl_assert_en, wl_assert_en, sl_assert_en},
          (k == 2) ? 7.0 : 0.0);
      chk("addr_tar", addr_tar, v.addr);
      chk("read_mode", read_mode, v.rd);
      chk("v_bl_sel", V_BL[v.addr[9:5]], v.vbl);
      chk("v_wl_sel", V_WL[v.addr[4:0]], ewl);
      chk("v_sl_sel", V_SL[v.addr[4:0]], esl);
      chk("v_sum", vsum(), es);
    end
    cyc = PC + 3;
    while (!resp_valid && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("resp_latency", cyc, v.lat);
    if (resp_valid) check_resp("op");
    @(negedge clk);
    chk("resp_valid_drop", resp_valid, 0.0);
    chk("req_ready_back", req_ready, 1.0);
    chk("idle_v_sum", vsum(), 0.0);
    chk("idle_strobes",
        {bl_assert_en, wl_assert_en, sl_assert_en, tran_en}, 0.0);
    chk("idle_addr_hold", addr_tar, v.addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int cyc;
    int seen;

    tbl[0] = mk(10'h041, 1'b0, 1.0, 1.2, 0.0);
    tbl[1] = mk(10'h3FF, 1'b1, 0.2, 0.0, 0.0);
    tbl[2] = mk(10'h3E0, 1'b0, 0.5, 2.0, 0.7);
    tbl[3] = mk(10'h000, 1'b1, 0.4, 0.0, 0.0);
    tbl[4] = mk(10'h01F, 1'b0, 0.3, 0.9, 0.1);
    tbl[5] = mk(10'h2A5, 1'b1, 1.0, 0.0, 0.0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0.0);
    chk("rst_resp_valid", resp_valid, 0.0);
    chk("rst_resp_i", resp_i, 0.0);
    chk("rst_resp_err", resp_err, 0.0);
    chk("rst_resp_tries", resp_tries, 0.0);
    chk("rst_addr_tar", addr_tar, 0.0);
    chk("rst_read_mode", read_mode, 1.0);
    chk("rst_v_sum", vsum(), 0.0);
    chk("rst_strobes",
        {bl_assert_en, wl_assert_en, sl_assert_en, tran_en}, 0.0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", req_ready, 1.0);

    // table-driven operations
    for (int i = 0; i < 6; i++) run_op(tbl[i]);

    // back-pressure on the response
    v = mk(10'h3FF, 1'b1, 0.2, 0.0, 0.0);
    @(negedge clk);
    resp_ready = 1'b0;
    drive_req(v);
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("bp_latency", cyc, PC + 4);
    req_valid = 1'b1;
    req_addr = 10'h123; req_read = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_resp_valid", resp_valid, 1.0);
      chk("bp_resp_i", resp_i, 70.0);
      chk("bp_req_ready", req_ready, 0.0);
      chk("bp_no_accept", addr_tar, 10'h3FF);
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (resp_valid) check_resp("bp");
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_accepted", resp_valid, 0.0);
    chk("bp_rdy_back", req_ready, 1.0);
    chk("bp_addr_hold", addr_tar, 10'h3FF);

    // reset in the middle of the pulse
    v = mk(10'h041, 1'b0, 1.0, 1.2, 0.0);
    req_valid = 1'b1;
    req_addr = v.addr; req_read = 1'b0;
    req_vbl = v.vbl; req_vwl = v.vwl; req_vsl = v.vsl;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    chk("mid_tran_before", tran_en, 1.0);
    rst_n = 1'b0;
    #1;
    chk("mid_tran_drop", tran_en, 0.0);
    chk("mid_resp_valid", resp_valid, 0.0);
    chk("mid_req_ready", req_ready, 0.0);
    chk("mid_addr_rst", addr_tar, 0.0);
    chk("mid_v_sum", vsum(), 0.0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("mid_no_resp", seen, 0.0);
    run_op(tbl[0]);

`ifdef MEM_OP_SEQ_VERIFY_EN
    // verify loop: failing window exhausts retries
    v = mk(10'h041, 1'b0, 1.0, 0.5, 0.0);
    v.ilo = 100.0; v.ihi = 1e9;
    v.et = 8; v.ee = 1'b1;
    v.lat = 8 * (2 * PC + 7) + 1;
    run_op(v);
    v = mk(10'h041, 1'b0, 1.0, 0.5, 0.0);
    run_op(v);
`endif

    chk("sb_empty", sb.size(), 0.0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
